// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART register-map APB arbiter: FSM encoding and
// the UART register addresses.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_CTRL = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_INT  = 4'hc;

endpackage

// File: rtl/uart_apb_arbiter_if.sv
// Requester command/response channels plus the APB bus of the UART arbiter.
// master = arbiter view; slave = requesters and APB slave view.
interface uart_apb_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  req0_done;
  logic [DATA_WIDTH-1:0] req0_rdata;
  logic                  req0_err;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  req1_done;
  logic [DATA_WIDTH-1:0] req1_rdata;
  logic                  req1_err;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. Grants only while en is high; on a tie the
// requester that did not win last time is chosen.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Shares the UART APB slave between two requesters: round-robin grant, one
// transfer in flight, PREADY wait states with a timeout abort.
module uart_apb_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                PCLK,
  input logic                PRESET,
  uart_apb_arbiter_if.master bus
);
  import uart_apb_pkg::*;

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

  apb_state_t            state, state_next;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  complete;
  logic                  abort;
  logic                  psel;
  logic                  penable;
  logic                  owner;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [1:0]            done_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];

  // Commands are only accepted in IDLE, and never while reset is held.
  assign arb_en = (state == IDLE) && !PRESET;

  rr_arbiter_2 u_arb (
    .clk   (PCLK),
    .rst   (PRESET),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (arb_en),
    .grant (grant)
  );

  assign complete = (state == ACCESS) && bus.PREADY;
  assign abort    = (state == ACCESS) && !bus.PREADY &&
                    (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE:   if (grant != 2'b00) state_next = SETUP;
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (complete || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the two-entry rdata array is plain flops, so it is reset like any other register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      owner    <= 1'b0;
      cnt      <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      for (int i = 0; i < 2; i++) rdata_q[i] <= '0;
    end else begin
      done_q <= 2'b00;
      if (grant != 2'b00) begin
        owner    <= grant[1];
        paddr_q  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
        pwrite_q <= grant[1] ? bus.req1_write : bus.req0_write;
        pwdata_q <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == SETUP) begin
        cnt <= '0;
      end else if ((state == ACCESS) && !bus.PREADY && !abort) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (complete) begin
        done_q[owner]  <= 1'b1;
        err_q[owner]   <= bus.PSLVERR;
        rdata_q[owner] <= pwrite_q ? '0 : bus.PRDATA;
      end else if (abort) begin
        done_q[owner]  <= 1'b1;
        err_q[owner]   <= 1'b1;
        rdata_q[owner] <= '1;
      end
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.PADDR      = paddr_q;
  assign bus.PSELx      = psel;
  assign bus.PENABLE    = penable;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PWDATA     = pwdata_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Bench for uart_apb_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_apb_arbiter;
  import uart_apb_pkg::*;

  localparam int TIMEOUT = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_apb_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  uart_apb_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one transfer record, phase 0 = SETUP, phase k = k-th ACCESS cycle.
  bit         m_busy  = 1'b0;
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_last  = 1;
  bit         m_write = 1'b0;
  logic [3:0] m_addr  = 4'h0;
  logic [7:0] m_wdata = 8'h00;
  logic       m_done  [2] = '{1'b0, 1'b0};
  logic       m_err   [2] = '{1'b0, 1'b0};
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};

  function automatic int winner();
    if (PRESET === 1'b1 || m_busy) return -1;
    if (bus.req0_valid && bus.req1_valid) return (m_last == 0) ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_busy = 1'b0; m_phase = 0; m_owner = 0; m_last = 1;
      m_write = 1'b0; m_addr = 4'h0; m_wdata = 8'h00;
      m_done = '{1'b0, 1'b0}; m_err = '{1'b0, 1'b0}; m_rdata = '{8'h00, 8'h00};
    end else begin
      int w;
      w = winner();
      m_done = '{1'b0, 1'b0};
      if (!m_busy) begin
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_busy  = 1'b1;
          m_phase = 0;
          m_write = (w == 0) ? bus.req0_write : bus.req1_write;
          m_addr  = (w == 0) ? bus.req0_addr  : bus.req1_addr;
          m_wdata = (w == 0) ? bus.req0_wdata : bus.req1_wdata;
        end
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (bus.PREADY) begin
        m_done[m_owner]  = 1'b1;
        m_err[m_owner]   = bus.PSLVERR;
        m_rdata[m_owner] = m_write ? 8'h00 : bus.PRDATA;
        m_busy = 1'b0;
      end else if (m_phase == TIMEOUT) begin
        m_done[m_owner]  = 1'b1;
        m_err[m_owner]   = 1'b1;
        m_rdata[m_owner] = 8'hFF;
        m_busy = 1'b0;
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge PCLK) begin
    int w;
    w = winner();
    check("cmp_ready0", 32'(bus.req0_ready), 32'(w == 0));
    check("cmp_ready1", 32'(bus.req1_ready), 32'(w == 1));
    check("cmp_done0",  32'(bus.req0_done),  32'(m_done[0]));
    check("cmp_done1",  32'(bus.req1_done),  32'(m_done[1]));
    check("cmp_err0",   32'(bus.req0_err),   32'(m_err[0]));
    check("cmp_err1",   32'(bus.req1_err),   32'(m_err[1]));
    check("cmp_rdata0", 32'(bus.req0_rdata), 32'(m_rdata[0]));
    check("cmp_rdata1", 32'(bus.req1_rdata), 32'(m_rdata[1]));
    check("cmp_psel",   32'(bus.PSELx),      32'(m_busy));
    check("cmp_penable", 32'(bus.PENABLE),   32'(m_busy && m_phase >= 1));
    check("cmp_paddr",  32'(bus.PADDR),      32'(m_addr));
    check("cmp_pwrite", 32'(bus.PWRITE),     32'(m_write));
    check("cmp_pwdata", 32'(bus.PWDATA),     32'(m_wdata));
  end

  task automatic start_req(input int n, input bit wr, input logic [3:0] a, input logic [7:0] d);
    @(posedge PCLK); #1;
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end
    @(negedge PCLK);
  endtask

  task automatic drop_req();
    @(posedge PCLK); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int order [16];
  int n_order, g0, g1, d0, d1;

  initial begin
    PRESET = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 4'h0; bus.req0_wdata = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 4'h0; bus.req1_wdata = 8'h00;
    bus.PREADY = 1'b1; bus.PRDATA = 8'h00; bus.PSLVERR = 1'b0;

    // Reset state
    @(negedge PCLK);
    check("rst_psel", 32'(bus.PSELx), 0);
    check("rst_penable", 32'(bus.PENABLE), 0);
    check("rst_rdata0", 32'(bus.req0_rdata), 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);

    // Single write with no wait states
    start_req(0, 1'b1, ADDR_CTRL, 8'hA5);
    check("t1_ready0", 32'(bus.req0_ready), 1);
    drop_req();
    check("t1_setup_psel", 32'(bus.PSELx), 1);
    check("t1_setup_penable", 32'(bus.PENABLE), 0);
    @(negedge PCLK);
    check("t1_access_penable", 32'(bus.PENABLE), 1);
    check("t1_paddr", 32'(bus.PADDR), 32'h4);
    check("t1_pwdata", 32'(bus.PWDATA), 32'hA5);
    check("t1_pwrite", 32'(bus.PWRITE), 1);
    @(negedge PCLK);
    check("t1_done0", 32'(bus.req0_done), 1);
    check("t1_err0", 32'(bus.req0_err), 0);

    // Read by requester 1
    bus.PRDATA = 8'h21;
    start_req(1, 1'b0, ADDR_STAT, 8'h00);
    check("t2_ready1", 32'(bus.req1_ready), 1);
    drop_req();
    @(negedge PCLK);
    @(negedge PCLK);
    check("t2_done1", 32'(bus.req1_done), 1);
    check("t2_rdata1", 32'(bus.req1_rdata), 32'h21);
    check("t2_err1", 32'(bus.req1_err), 0);
    check("t2_done0", 32'(bus.req0_done), 0);
    check("t2_rdata0", 32'(bus.req0_rdata), 0);

    // Contention: both requesters hold valid for four transfers each
    bus.PRDATA = 8'h44;
    for (int i = 0; i < 16; i++) order[i] = -1;
    n_order = 0; g0 = 0; g1 = 0; d0 = 0; d1 = 0;
    @(posedge PCLK); #1;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = ADDR_DATA; bus.req0_wdata = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = ADDR_CTRL;
    for (int cyc = 0; cyc < 80 && !(d0 == 4 && d1 == 4); cyc++) begin
      @(negedge PCLK);
      if (bus.req0_ready && n_order < 16) begin order[n_order] = 0; n_order++; g0++; end
      if (bus.req1_ready && n_order < 16) begin order[n_order] = 1; n_order++; g1++; end
      if (bus.req0_done) d0++;
      if (bus.req1_done) d1++;
      @(posedge PCLK); #1;
      if (g0 >= 4) bus.req0_valid = 1'b0;
      if (g1 >= 4) bus.req1_valid = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("t3_done0_count", d0, 4);
    check("t3_done1_count", d1, 4);
    check("t3_grant_count", n_order, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_order%0d", i), order[i], i % 2);
    @(negedge PCLK);

    // Five wait states, then PREADY
    bus.PREADY = 1'b0;
    start_req(0, 1'b1, ADDR_INT, 8'h5A);
    check("t4_ready0", 32'(bus.req0_ready), 1);
    drop_req();
    for (int k = 2; k <= 7; k++) begin
      @(posedge PCLK); #1;
      if (k == 7) bus.PREADY = 1'b1;
      @(negedge PCLK);
      check("t4_psel", 32'(bus.PSELx), 1);
      check("t4_penable", 32'(bus.PENABLE), 1);
      check("t4_paddr", 32'(bus.PADDR), 32'hC);
      check("t4_pwdata", 32'(bus.PWDATA), 32'h5A);
      check("t4_pwrite", 32'(bus.PWRITE), 1);
      check("t4_no_done", 32'(bus.req0_done), 0);
    end
    @(negedge PCLK);
    check("t4_done0", 32'(bus.req0_done), 1);
    check("t4_err0", 32'(bus.req0_err), 0);

    // PREADY stuck low: abort after 16 ACCESS cycles
    bus.PREADY = 1'b0;
    start_req(1, 1'b0, ADDR_INT, 8'h00);
    drop_req();
    for (int k = 2; k <= 17; k++) begin
      @(negedge PCLK);
      check("t5_penable", 32'(bus.PENABLE), 1);
      check("t5_no_done", 32'(bus.req1_done), 0);
    end
    @(negedge PCLK);
    check("t5_done1", 32'(bus.req1_done), 1);
    check("t5_err1", 32'(bus.req1_err), 1);
    check("t5_rdata1", 32'(bus.req1_rdata), 32'hFF);
    check("t5_psel", 32'(bus.PSELx), 0);
    bus.PREADY = 1'b1;

    // Slave error on a read
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 8'h33;
    start_req(0, 1'b0, 4'h2, 8'h00);
    drop_req();
    @(negedge PCLK);
    @(negedge PCLK);
    check("t6_done0", 32'(bus.req0_done), 1);
    check("t6_err0", 32'(bus.req0_err), 1);
    check("t6_rdata0", 32'(bus.req0_rdata), 32'h33);
    bus.PSLVERR = 1'b0;

    // Reset during ACCESS; req0 must win first afterwards
    bus.PREADY = 1'b0;
    start_req(0, 1'b0, ADDR_STAT, 8'h00);
    drop_req();
    @(negedge PCLK);
    check("t7_in_access", 32'(bus.PENABLE), 1);
    #2;
    PRESET = 1'b1;
    #1;
    check("t7_async_psel", 32'(bus.PSELx), 0);
    check("t7_async_penable", 32'(bus.PENABLE), 0);
    check("t7_no_done", 32'(bus.req0_done), 0);
    repeat (2) @(negedge PCLK);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    bus.PREADY = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = ADDR_INT; bus.req0_wdata = 8'h77;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = ADDR_CTRL;
    @(negedge PCLK);
    check("t7_ready0_first", 32'(bus.req0_ready), 1);
    check("t7_ready1_wait", 32'(bus.req1_ready), 0);
    drop_req();
    @(negedge PCLK);
    @(negedge PCLK);
    check("t7_done0", 32'(bus.req0_done), 1);
    check("t7_err0", 32'(bus.req0_err), 0);
    check("t7_done1_never", 32'(bus.req1_done), 0);
    repeat (4) @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_arbiter.md
Name: uart_apb_arbiter

Overview:
- Two-requester APB master that shares the single UART register-map slave between requesters, e.g. CPU bridge (req0) and DMA/test engine (req1).
- Round-robin grant, one transfer in flight.
- Generates the APB SETUP/ACCESS sequence and honours PREADY wait states.
- Returns read data and error per requester, with a PREADY timeout so a stalled slave cannot hang either requester.

Parameters:
- ADDR_WIDTH, 4, APB address width (matches UART register map).
- DATA_WIDTH, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY before abort (≥2).

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 command valid; held until req0_ready
req0_write  in  1  1 write, 0 read
req0_addr  in  ADDR_WIDTH  register address
req0_wdata  in  DATA_WIDTH  write data
req0_ready  out  1  command accepted this cycle
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_WIDTH  read data, valid with req0_done
req0_err  out  1  slave error or timeout, valid with req0_done
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err: identical for requester 1
PADDR  out  ADDR_WIDTH  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESET=1): state IDLE; PSELx, PENABLE, PWRITE, PADDR, PWDATA = 0; all reqN_ready, reqN_done, reqN_err = 0; reqN_rdata = 0; last_grant = 1, so req0 wins first; timeout counter = 0. A transfer in flight is dropped silently: no done pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any reqN_valid, pick the winner: the single valid requester, or if both are valid, the one ≠ last_grant.
  - reqN_ready is combinational high for the winner in that cycle.
  - At the clock edge: latch write/addr/wdata into the APB outputs, record the owner, update last_grant, go to SETUP.
  - With no valid request: stay in IDLE, APB outputs hold value, PSELx = 0.
- SETUP: PSELx = 1, PENABLE = 0; unconditionally go to ACCESS next cycle.
- ACCESS: PSELx = 1, PENABLE = 1; PADDR, PWRITE, PWDATA stable.
  - If PREADY = 1: sample PRDATA (reads only; writes return 0) and PSLVERR into the owner's rdata/err. Next cycle: owner's reqN_done = 1 for exactly one cycle. Go to IDLE with PSELx = PENABLE = 0.
  - If PREADY = 0: increment the counter. When the counter reaches TIMEOUT_CYCLES−1 without PREADY, abort: deassert PSELx/PENABLE, owner's done = 1 with err = 1 and rdata = all ones, go to IDLE.
  - Counter clears on entry to SETUP.
- Throughput: a transfer with no wait states takes 3 cycles (IDLE→SETUP→ACCESS). The done pulse coincides with the next IDLE cycle, and a new request can be accepted in that same cycle.
- reqN_rdata/reqN_err hold their value until the next completion for that requester.
- The non-owner's done is never asserted. reqN_ready and reqN_done are never both high for the same requester in one cycle, except accept-on-done in IDLE, which is allowed.
- A requester dropping valid before ready: the command is ignored, with no side effect.
- PSLVERR is sampled only when PREADY = 1 in ACCESS; ignored otherwise.

Decomposition:
- Shared package uart_apb_pkg: FSM state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2) and register address constants (DATA 4'h0, CTRL 4'h4, STAT 4'h8, INT 4'hc).
- One sub-module: rr_arbiter_2 — 2-way round-robin grant with registered last_grant and grant-enable input.

Test Plan:
- Single write: req0 write addr 4'h4 data 8'hA5, PREADY tied 1 → req0_ready cycle 0. APB SETUP cycle 1, ACCESS cycle 2 with PADDR = 4, PWDATA = A5, PWRITE = 1. req0_done cycle 3, req0_err = 0.
- Read: req1 read addr 4'h8, slave PRDATA = 8'h21 → req1_done with req1_rdata = 8'h21, err = 0; req0 outputs unchanged.
- Contention: both valid continuously, 4 transfers each → grants alternate 0,1,0,1…. Each requester gets exactly 4 done pulses, with no back-to-back grant to the same requester.
- Wait states: PREADY held 0 for 5 ACCESS cycles then 1 → APB signals stable throughout, done one cycle after PREADY, err = 0.
- Timeout and slave error:
  - PREADY stuck 0 → abort after 16 ACCESS cycles; done with err = 1, rdata = 8'hFF.
  - Read at addr 4'h2 with PSLVERR = 1 → err = 1.
- Reset mid-ACCESS: assert PRESET during ACCESS → PSELx/PENABLE drop asynchronously, no done pulse. After release, req0 is granted first.
